// File: rtl/std_ram_be.sv
// Simple-dual-port RAM with byte-enable writes, 0/1/2-cycle reads and a
// self-sequenced clear sweep that fills every word with INITIAL_VALUE.
module std_ram_be #(
  parameter int WORD_SIZE = 1,
  parameter int ADDRESS_WIDTH = (WORD_SIZE >= 2) ? $clog2(WORD_SIZE) : 1,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter bit WRITE_FIRST = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  output logic                     o_busy,
  input  logic                     i_mea,
  input  logic                     i_wea,
  input  logic [BE_WIDTH-1:0]      i_bea,
  input  logic [ADDRESS_WIDTH-1:0] i_adra,
  input  logic [DATA_WIDTH-1:0]    i_da,
  input  logic                     i_meb,
  input  logic [ADDRESS_WIDTH-1:0] i_adrb,
  output logic [DATA_WIDTH-1:0]    o_qb,
  output logic                     o_vb
);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic [ADDRESS_WIDTH:0] DEPTH =
    (ADDRESS_WIDTH+1)'(WORD_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(WORD_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [WORD_SIZE];

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  logic                  a_in, b_in;
  logic                  we, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  assign o_busy = (state_q == SWEEP);
  assign a_in   = {1'b0, i_adra} < DEPTH;
  assign b_in   = {1'b0, i_adrb} < DEPTH;
  assign we     = !o_busy && i_mea && i_wea && a_in;
  assign rd_acc = i_meb && !o_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SWEEP: begin
        if (i_clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (i_clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Storage has no reset; the sweep provides the defined initial state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (o_busy) begin
        mem[cnt_q] <= INITIAL_VALUE;
      end else if (we) begin
        for (int k = 0; k < BE_WIDTH; k++) begin
          if (i_bea[k]) begin
            mem[i_adra][k*BYTE_WIDTH +: BYTE_WIDTH] <=
              i_da[k*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = INITIAL_VALUE;
    if (b_in) begin
      rd_word = mem[i_adrb];
    end
  end

  if (READ_LATENCY == 0) begin : g_rl0
    assign o_qb = rd_word;
    assign o_vb = rd_acc;
  end else begin : g_rl
    logic                  col;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;

    assign col = rd_acc && we && (i_adrb == i_adra);

    always_comb begin
      merged = rd_word;
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (i_bea[k]) begin
          merged[k*BYTE_WIDTH +: BYTE_WIDTH] =
            i_da[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst || i_clr) begin
        d1 <= INITIAL_VALUE;
        v1 <= 1'b0;
      end else begin
        v1 <= rd_acc;
        if (rd_acc) begin
          d1 <= (WRITE_FIRST && col) ? merged : rd_word;
        end
      end
    end

    if (READ_LATENCY == 1) begin : g_rl1
      assign o_qb = d1;
      assign o_vb = v1;
    end else begin : g_rl2
      logic [DATA_WIDTH-1:0] d2;
      logic                  v2;

      always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr) begin
          d2 <= INITIAL_VALUE;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            d2 <= d1;
          end
        end
      end

      assign o_qb = d2;
      assign o_vb = v2;
    end
  end

endmodule

// File: tb/tb_std_ram_be.sv
// Directed bench for std_ram_be: five instances share one stimulus stream
// (latency 0/1/2, write-first, and a 12-word non-power-of-two array).
module tb_std_ram_be;

  logic        clk = 1'b0;
  logic        rst, clr, mea, wea, meb;
  logic [3:0]  bea, adra, adrb;
  logic [31:0] da;

  logic        busy0, busy1, busyw, busy2, busyn;
  logic        vb0, vb1, vbw, vb2, vbn;
  logic [31:0] qb0, qb1, qbw, qb2, qbn;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  std_ram_be #(.WORD_SIZE(16), .READ_LATENCY(0)) u_rl0 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy0),
    .i_mea(mea), .i_wea(wea), .i_bea(bea), .i_adra(adra), .i_da(da),
    .i_meb(meb), .i_adrb(adrb), .o_qb(qb0), .o_vb(vb0));

  std_ram_be #(.WORD_SIZE(16), .READ_LATENCY(1)) u_rl1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy1),
    .i_mea(mea), .i_wea(wea), .i_bea(bea), .i_adra(adra), .i_da(da),
    .i_meb(meb), .i_adrb(adrb), .o_qb(qb1), .o_vb(vb1));

  std_ram_be #(.WORD_SIZE(16), .READ_LATENCY(1), .WRITE_FIRST(1'b1)) u_wf (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busyw),
    .i_mea(mea), .i_wea(wea), .i_bea(bea), .i_adra(adra), .i_da(da),
    .i_meb(meb), .i_adrb(adrb), .o_qb(qbw), .o_vb(vbw));

  std_ram_be #(.WORD_SIZE(16), .READ_LATENCY(2)) u_rl2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy2),
    .i_mea(mea), .i_wea(wea), .i_bea(bea), .i_adra(adra), .i_da(da),
    .i_meb(meb), .i_adrb(adrb), .o_qb(qb2), .o_vb(vb2));

  std_ram_be #(.WORD_SIZE(12), .ADDRESS_WIDTH(4), .READ_LATENCY(1)) u_n12 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busyn),
    .i_mea(mea), .i_wea(wea), .i_bea(bea), .i_adra(adra), .i_da(da),
    .i_meb(meb), .i_adrb(adrb), .o_qb(qbn), .o_vb(vbn));

  function automatic logic [31:0] pat(int a);
    return 32'(a) * 32'h0101_0101;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n16, n12;
    rst = 1'b0; clr = 1'b0; mea = 1'b0; wea = 1'b0; meb = 1'b0;
    bea = '0; adra = '0; adrb = '0; da = '0;
    repeat (3) tick;
    total++;
    if (busy1 !== 1'b1) begin
      bad++; $display("FAIL rst_busy got=%b want=1", busy1);
    end
    total++;
    if (vb1 !== 1'b0 || vb2 !== 1'b0) begin
      bad++; $display("FAIL rst_vb got=%b%b want=00", vb1, vb2);
    end
    total++;
    if (qb1 !== 32'h0 || qb2 !== 32'h0) begin
      bad++; $display("FAIL rst_qb got=%h/%h want=0", qb1, qb2);
    end
    rst = 1'b1;
    n16 = 0;
    n12 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy1) n16++;
      if (busyn) n12++;
      tick;
    end
    total++;
    if (n16 != 16) begin
      bad++; $display("FAIL sweep16_len got=%0d want=16", n16);
    end
    total++;
    if (n12 != 12) begin
      bad++; $display("FAIL sweep12_len got=%0d want=12", n12);
    end
    for (int a = 0; a < 16; a++) begin
      meb = 1'b1; adrb = 4'(a);
      tick;
      total++;
      if ({vb1, qb1} !== {1'b1, 32'h0}) begin
        bad++; $display("FAIL rst_read a=%0d got=%b/%h want=1/0", a, vb1, qb1);
      end
    end
    meb = 1'b0;
    tick;
  endtask

  task automatic test_byte_enable;
    mea = 1'b1; wea = 1'b1; adra = 4'd5;
    da = 32'hAABB_CCDD; bea = 4'b1111;
    tick;
    da = 32'h1122_3344; bea = 4'b0101;
    tick;
    mea = 1'b0; wea = 1'b0;
    meb = 1'b1; adrb = 4'd5;
    tick;
    total++;
    if ({vb1, qb1} !== {1'b1, 32'hAA22_CC44}) begin
      bad++; $display("FAIL be_merge got=%b/%h want=1/aa22cc44", vb1, qb1);
    end
    meb = 1'b0;
    tick;
    total++;
    if ({vb1, qb1} !== {1'b0, 32'hAA22_CC44}) begin
      bad++; $display("FAIL be_hold got=%b/%h want=0/aa22cc44", vb1, qb1);
    end
    mea = 1'b1; wea = 1'b1; da = 32'h0; bea = 4'b0000;
    tick;
    mea = 1'b0; wea = 1'b0;
    meb = 1'b1;
    tick;
    total++;
    if (qb1 !== 32'hAA22_CC44) begin
      bad++; $display("FAIL be_zero got=%h want=aa22cc44", qb1);
    end
    meb = 1'b0;
    tick;
  endtask

  task automatic test_collision;
    mea = 1'b1; wea = 1'b1; adra = 4'd3;
    da = 32'hFFFF_FFFF; bea = 4'b0011;
    meb = 1'b1; adrb = 4'd3;
    #1;
    total++;
    if (qb0 !== 32'h0) begin
      bad++; $display("FAIL col_rl0 got=%h want=00000000", qb0);
    end
    tick;
    total++;
    if (qb1 !== 32'h0) begin
      bad++; $display("FAIL col_rf got=%h want=00000000", qb1);
    end
    total++;
    if (qbw !== 32'h0000_FFFF) begin
      bad++; $display("FAIL col_wf got=%h want=0000ffff", qbw);
    end
    mea = 1'b0; wea = 1'b0;
    tick;
    total++;
    if (qb1 !== 32'h0000_FFFF || qbw !== 32'h0000_FFFF) begin
      bad++; $display("FAIL col_after got=%h/%h want=0000ffff", qb1, qbw);
    end
    meb = 1'b0;
    tick;
  endtask

  task automatic test_latency;
    mea = 1'b1; wea = 1'b1; bea = 4'b1111;
    for (int a = 0; a < 16; a++) begin
      adra = 4'(a); da = pat(a);
      tick;
    end
    mea = 1'b0; wea = 1'b0;
    tick;
    for (int c = 0; c < 18; c++) begin
      meb = (c < 16);
      adrb = 4'(c);
      #1;
      total++;
      if (c < 16 ? ({vb0, qb0} !== {1'b1, pat(c)}) : (vb0 !== 1'b0)) begin
        bad++; $display("FAIL lat0 c=%0d got=%b/%h", c, vb0, qb0);
      end
      tick;
      total++;
      if (c < 16 ? ({vb1, qb1} !== {1'b1, pat(c)}) : (vb1 !== 1'b0)) begin
        bad++; $display("FAIL lat1 c=%0d got=%b/%h", c, vb1, qb1);
      end
      total++;
      if ((c >= 1 && c <= 16) ? ({vb2, qb2} !== {1'b1, pat(c - 1)})
                              : (vb2 !== 1'b0)) begin
        bad++; $display("FAIL lat2 c=%0d got=%b/%h", c, vb2, qb2);
      end
    end
    meb = 1'b0;
    tick;
  endtask

  task automatic test_nonpow2;
    mea = 1'b1; wea = 1'b1; adra = 4'd13;
    da = 32'hDEAD_BEEF; bea = 4'b1111;
    tick;
    mea = 1'b0; wea = 1'b0;
    meb = 1'b1; adrb = 4'd13;
    tick;
    total++;
    if ({vbn, qbn} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL np2_oor got=%b/%h want=1/0", vbn, qbn);
    end
    total++;
    if (qb1 !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL np2_big got=%h want=deadbeef", qb1);
    end
    adrb = 4'd11;
    tick;
    total++;
    if ({vbn, qbn} !== {1'b1, 32'h0B0B_0B0B}) begin
      bad++; $display("FAIL np2_last got=%b/%h want=1/0b0b0b0b", vbn, qbn);
    end
    meb = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    int n;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy1) break;
      n++;
      clr = (n == 7);
      mea = 1'b1; wea = 1'b1; adra = 4'd2;
      da = 32'h1234_5678; bea = 4'b1111;
      meb = 1'b1; adrb = 4'd2;
      total++;
      if (vb1 !== 1'b0) begin
        bad++; $display("FAIL clr_vb1 n=%0d got=%b want=0", n, vb1);
      end
      #1;
      total++;
      if (vb0 !== 1'b0) begin
        bad++; $display("FAIL clr_vb0 n=%0d got=%b want=0", n, vb0);
      end
      tick;
    end
    clr = 1'b0; mea = 1'b0; wea = 1'b0; meb = 1'b0;
    total++;
    if (n != 23) begin
      bad++; $display("FAIL clr_len got=%0d want=23", n);
    end
    for (int a = 0; a < 16; a++) begin
      meb = 1'b1; adrb = 4'(a);
      tick;
      total++;
      if ({vb1, qb1, vbw, qbw} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
        bad++;
        $display("FAIL clr_read a=%0d got=%b/%h %b/%h want=1/0",
                 a, vb1, qb1, vbw, qbw);
      end
    end
    meb = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_byte_enable;
    test_collision;
    test_latency;
    test_nonpow2;
    test_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
